// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the RISC-V memory access port.
package rv_mem_pkg;

    // Port controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } mp_state_t;

    // Kind of access latched when a request is accepted.
    typedef enum logic [1:0] {
        K_FETCH = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } mp_kind_t;

    // Default watchdog limit: cycles of mem_req without mem_ready before fault.
    localparam int TMO_CYC_DEFAULT = 64;

    // Resolve simultaneous strobes: store beats load beats fetch.
    function automatic mp_kind_t pick_kind(input logic st, input logic ld);
        if (st)      return K_STORE;
        else if (ld) return K_LOAD;
        else         return K_FETCH;
    endfunction

endpackage

// File: rtl/rv_mem_wdog.sv
// Access watchdog: up-counter cleared on access entry, counting while the
// access is outstanding, flagging the last permitted cycle.
module rv_mem_wdog #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tmo
);

    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    logic [CW-1:0] count;

    // Count cycles of an outstanding access; clear has priority over enable.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + 1'b1;
    end

    assign tmo = en && (count == CW'(TMO_CYC - 1));

endmodule

// File: rtl/rv_mem_port.sv
// Memory access port: turns single-cycle fetch/load/store strobes from the
// multicycle control FSM into a held req/ready handshake with stall and a
// watchdog. Optional build macro MEM_ALIGN_CHECK_EN faults misaligned requests
// instead of silently word-aligning them.
module rv_mem_port
    import rv_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          stall,
    output logic          fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    mp_state_t     state_q, state_d;
    mp_kind_t      kind_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          any_req;
    logic          misalign;
    logic          take;
    logic          wd_tmo;

    assign any_req = fetch_req | ld_req | st_req;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State register; reset drops mem_req immediately since outputs decode from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    stall = 1'b1;
                    if (misalign) begin
                        state_d = FAULT;
                    end else begin
                        state_d = ACCESS;
                        take    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = (kind_q == K_STORE);
                if (mem_ready)   state_d = DONE;
                else if (wd_tmo) state_d = FAULT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAULT: begin
                fault = 1'b1;
                stall = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request so datapath inputs may move after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q  <= K_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            kind_q  <= pick_kind(st_req, ld_req);
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Capture read data on completion of a fetch or load; stores keep the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state_q == ACCESS && mem_ready && kind_q != K_STORE)
            rdata_q <= mem_rdata;
    end

    assign mem_addr  = addr_q & ~AW'(3);
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

    rv_mem_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (take),
        .en  (state_q == ACCESS),
        .tmo (wd_tmo)
    );

endmodule
